// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the P5 pipeline hazard controller.
//   TUSE_NONE        - Tuse code meaning "source register not read"
//   FWD_D_* / FWD_E_* / FWD_M_* - forwarding-mux select encodings per stage
//   stage_t          - shadow-stage record {rs, rt, a3, tnew}; the decoder's
//                      Tuse/Tnew table produces the same record
//   tnew_dec         - saturating decrement applied as an instruction ages
//   reg_match        - true when a nonzero source register equals a stage's a3
package hazard_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_D_GRF = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;
  localparam logic [1:0] FWD_D_W   = 2'd3;

  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;

  localparam logic FWD_M_REG = 1'b0;
  localparam logic FWD_M_W   = 1'b1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // $0 is hardwired to zero, so it can never be a true dependency.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] a3);
    return (r != 5'd0) && (r == a3);
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// hazard_shadow_pipe: E/M/W shadow registers of destination numbers and
// remaining result latency, advanced every cycle.
//   clk, reset     - clock and asynchronous active-high reset
//   stall          - when high, a bubble enters E instead of the D record
//   d              - D-stage record {rs, rt, a3, tnew}
//   e              - E-stage record
//   m_rt/m_a3/m_tnew - M-stage fields (rs is no longer needed by M)
//   w_a3           - W-stage destination (its tnew is always 0)
module hazard_shadow_pipe
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  stage_t     d,
  output stage_t     e,
  output logic [4:0] m_rt,
  output logic [4:0] m_a3,
  output logic [1:0] m_tnew,
  output logic [4:0] w_a3
);

  // W keeps no tnew: a result reaching W is always ready, so the M->W
  // decrement is never stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e      <= STAGE_BUBBLE;
      m_rt   <= 5'd0;
      m_a3   <= 5'd0;
      m_tnew <= 2'd0;
      w_a3   <= 5'd0;
    end else begin
      e      <= stall ? STAGE_BUBBLE : d;
      m_rt   <= e.rt;
      m_a3   <= e.a3;
      m_tnew <= tnew_dec(e.tnew);
      w_a3   <= m_a3;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding-select generation for the P5 MIPS core.
// Compares D-stage sources and their Tuse against the shadow E/M/W stages.
//   clk, reset           - clock and asynchronous active-high reset
//   d_rs, d_rt           - D-stage source registers
//   d_tuse_rs, d_tuse_rt - cycles until consumed (3 = not read)
//   d_a3, d_tnew         - D-stage destination and its latency on entry to E
//   stall                - freeze PC and F/D, bubble into E
//   fwd_d_rs/fwd_d_rt    - D mux selects (0 GRF, 1 E, 2 M, 3 W)
//   fwd_e_rs/fwd_e_rt    - E mux selects (0 D/E reg, 1 M, 2 W)
//   fwd_m_rt             - M store-data select (0 E/M reg, 1 W)
// Build option: define HAZARD_FWD_EN to enable forwarding. Without it all
// selects are 0 and any dependency on E, M or W stalls until write-back.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt
);

  stage_t     d_st;
  stage_t     e_st;
  logic [4:0] m_rt;
  logic [4:0] m_a3;
  logic [1:0] m_tnew;
  logic [4:0] w_a3;

  assign d_st = '{rs: d_rs, rt: d_rt, a3: d_a3, tnew: d_tnew};

  hazard_shadow_pipe u_shadow (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .d      (d_st),
    .e      (e_st),
    .m_rt   (m_rt),
    .m_a3   (m_a3),
    .m_tnew (m_tnew),
    .w_a3   (w_a3)
  );

`ifdef HAZARD_FWD_EN

  // The nearest matching stage owns the value: a newer writer in E hides an
  // older one in M even if the older one would have forced a stall.
  function automatic logic hazard_on(input logic [4:0] r, input logic [1:0] tuse,
                                     input stage_t e, input logic [4:0] ma3,
                                     input logic [1:0] mtnew);
    if (tuse == TUSE_NONE)  return 1'b0;
    if (reg_match(r, e.a3)) return e.tnew > tuse;
    return reg_match(r, ma3) && (mtnew > tuse);
  endfunction

  // A match whose result is not ready yet selects the register path; the
  // stale value is replaced by a later-stage mux once the result exists.
  function automatic logic [1:0] d_sel(input logic [4:0] r, input stage_t e,
                                       input logic [4:0] ma3, input logic [1:0] mtnew,
                                       input logic [4:0] wa3);
    if (reg_match(r, e.a3)) return (e.tnew == 2'd0) ? FWD_D_E : FWD_D_GRF;
    if (reg_match(r, ma3))  return (mtnew == 2'd0) ? FWD_D_M : FWD_D_GRF;
    if (reg_match(r, wa3))  return FWD_D_W;
    return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] r, input logic [4:0] ma3,
                                       input logic [1:0] mtnew, input logic [4:0] wa3);
    if (reg_match(r, ma3)) return (mtnew == 2'd0) ? FWD_E_M : FWD_E_REG;
    if (reg_match(r, wa3)) return FWD_E_W;
    return FWD_E_REG;
  endfunction

  assign stall    = hazard_on(d_rs, d_tuse_rs, e_st, m_a3, m_tnew)
                  | hazard_on(d_rt, d_tuse_rt, e_st, m_a3, m_tnew);
  assign fwd_d_rs = d_sel(d_rs, e_st, m_a3, m_tnew, w_a3);
  assign fwd_d_rt = d_sel(d_rt, e_st, m_a3, m_tnew, w_a3);
  assign fwd_e_rs = e_sel(e_st.rs, m_a3, m_tnew, w_a3);
  assign fwd_e_rt = e_sel(e_st.rt, m_a3, m_tnew, w_a3);
  assign fwd_m_rt = reg_match(m_rt, w_a3) ? FWD_M_W : FWD_M_REG;

`else

  // Without forwarding a source may only be read once its writer has left W.
  function automatic logic depends(input logic [4:0] r, input logic [1:0] tuse,
                                   input logic [4:0] ea3, input logic [4:0] ma3,
                                   input logic [4:0] wa3);
    return (tuse != TUSE_NONE) &&
           (reg_match(r, ea3) || reg_match(r, ma3) || reg_match(r, wa3));
  endfunction

  // Shadow fields that only the forwarding logic consumes.
  logic fwd_unused;
  assign fwd_unused = ^{e_st.rs, e_st.rt, e_st.tnew, m_rt, m_tnew};

  assign stall    = depends(d_rs, d_tuse_rs, e_st.a3, m_a3, w_a3)
                  | depends(d_rt, d_tuse_rt, e_st.a3, m_a3, w_a3);
  assign fwd_d_rs = FWD_D_GRF;
  assign fwd_d_rt = FWD_D_GRF;
  assign fwd_e_rs = FWD_E_REG;
  assign fwd_e_rt = FWD_E_REG;
  assign fwd_m_rt = FWD_M_REG;

`endif

endmodule
